vram_mirror: RTL

- Memory-side responder for the video controller's VRAM fetch interface.
- Keeps a 32 KB single-port screen RAM holding banks 5 and 7.
- Serves video fetches with guaranteed latency.
- Mirrors CPU memory writes that hit screen banks, queuing them in a small FIFO and draining them into RAM in cycles the video port does not need.

---
 rtl/vram_mirror.sv | 114 +++++++++++
 1 files changed

// File: rtl/vram_mirror.sv
// rtl/vram_mirror.sv - 32 KB screen RAM serving video fetches and mirroring CPU screen writes through a small queue
module vram_mirror #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               clk_sys,
    input  logic               nRESET,
    input  logic               ce_7mn,
    input  logic [14:0]        vram_addr,
    output logic [7:0]         vram_dout,
    input  logic [15:0]        addr,
    input  logic [7:0]         din,
    input  logic               nMREQ,
    input  logic               nWR,
    input  logic               nRFSH,
    input  logic               m128,
    input  logic [2:0]         page_ram,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               ovf
);
    typedef enum logic [1:0] {IDLE, RD_A, RD_D, WR} state_t;

    localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    state_t               state, state_nx;
    logic [7:0]           ram [0:32767];
    logic [22:0]          fifo [0:FIFO_DEPTH-1];
    logic [22:0]          head;
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic                 wr_q, pending;
    logic [7:0]           q;
    logic                 wr_cond, top_quarter, hit5, hit7, push, pop, full, accept;
    logic                 we, re;
    logic [14:0]          ram_addr;

    // CPU capture: one push per rising edge of the write condition, screen banks only
    assign wr_cond     = ~nMREQ & ~nWR & nRFSH;
    assign top_quarter = (addr[15:14] == 2'b11);
    assign hit5        = (addr[15:14] == 2'b01) | (m128 & top_quarter & (page_ram == 3'd5));
    assign hit7        = m128 & top_quarter & (page_ram == 3'd7);
    assign push        = wr_cond & ~wr_q & (hit5 | hit7);
    assign full        = (fifo_level == LEVEL_FULL);
    assign pop         = (state == WR);
    assign accept      = push & (~full | pop);
    assign head        = fifo[rd_ptr];

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            pending    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf        <= 1'b0;
            vram_dout  <= 8'h00;
        end else begin
            state   <= state_nx;
            wr_q    <= wr_cond;
            // a strobe seen while busy is held until the FSM is back in IDLE
            pending <= (state != IDLE) & (ce_7mn | pending);
            if (accept)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            if (push & ~accept)
                ovf <= 1'b1;
            if (state == RD_D)
                vram_dout <= q;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (ce_7mn | pending)
                    state_nx = RD_A;
                else if (fifo_level != '0)
                    state_nx = WR;
            end
            RD_A:    state_nx = RD_D;
            RD_D:    state_nx = IDLE;
            WR:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        we       = (state == WR);
        re       = (state == RD_A);
        ram_addr = we ? {head[22], head[21:8]} : vram_addr;
    end

    always_ff @(posedge clk_sys) begin
        if (accept)
            fifo[wr_ptr] <= {hit7, addr[13:0], din};
    end

    // single-port screen RAM; contents survive reset
    always_ff @(posedge clk_sys) begin
        if (we)
            ram[ram_addr] <= head[7:0];
        if (re)
            q <= ram[ram_addr];
    end
endmodule
